// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: MSB-first bit assembly into a one-entry valid/ready holding register.
// Optional even-parity bit per frame is compiled in with `define SERIAL_TO_PARALLEL_PARITY_EN.
module serial_to_parallel #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_enable,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] parallel_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int COUNT_W = $clog2(DATA_WIDTH);
    localparam logic [COUNT_W-1:0] LAST_BIT = COUNT_W'(DATA_WIDTH - 1);

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] load_word;
    logic [COUNT_W-1:0]    count, count_next;
    logic                  load_req;
    logic                  frame_err_next;
    logic                  parity_err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        shift_next      = shift_reg;
        count_next      = count;
        load_req        = 1'b0;
        load_word       = shift_reg;
        frame_err_next  = 1'b0;
        parity_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (rx_enable) begin
                    shift_next = {shift_reg[DATA_WIDTH-2:0], serial_in};
                    count_next = COUNT_W'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (rx_enable) begin
                    shift_next = {shift_reg[DATA_WIDTH-2:0], serial_in};
                    if (count == LAST_BIT) begin
                        count_next = '0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
                        state_next = PARITY;
`else
                        load_req   = 1'b1;
                        load_word  = shift_next;
                        state_next = IDLE;
`endif
                    end else begin
                        count_next = count + COUNT_W'(1);
                    end
                end else begin
                    // enable dropped before the last data bit: the partial word is thrown away
                    frame_err_next = 1'b1;
                    shift_next     = '0;
                    count_next     = '0;
                    state_next     = IDLE;
                end
            end
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
            PARITY: begin
                if (rx_enable) begin
                    load_req        = 1'b1;
                    load_word       = shift_reg;
                    parity_err_next = (^shift_reg) ^ serial_in;
                end else begin
                    frame_err_next = 1'b1;
                    shift_next     = '0;
                end
                state_next = IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg     <= '0;
            count         <= '0;
            parallel_data <= '0;
            rx_valid      <= 1'b0;
            overrun       <= 1'b0;
            frame_err     <= 1'b0;
            parity_err    <= 1'b0;
        end else begin
            shift_reg  <= shift_next;
            count      <= count_next;
            frame_err  <= frame_err_next;
            parity_err <= parity_err_next;
            // a pop on the load edge frees the slot, so the new word still lands
            if (load_req) begin
                if (!rx_valid || rx_ready) begin
                    parallel_data <= load_word;
                    rx_valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel: delivered words are queued at send time and
// compared when the consumer pops them; flags are checked at fixed points after each edge.
module tb_serial_to_parallel;

    localparam int DATA_WIDTH = 8;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    localparam int FRAME = DATA_WIDTH + 1;
    localparam int NUM_POPS = 8;
`else
    localparam int FRAME = DATA_WIDTH;
    localparam int NUM_POPS = 6;
`endif

    logic                  clk;
    logic                  rst;
    logic                  rx_enable;
    logic                  serial_in;
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  overrun;
    logic                  frame_err;
    logic                  parity_err;

    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic [7:0]     sb_q[$];
    int             pop_cyc[$];

    serial_to_parallel #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_enable    (rx_enable),
        .serial_in    (serial_in),
        .parallel_data(parallel_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .overrun      (overrun),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // consumer side of the scoreboard: every pop must match the oldest queued word
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            pop_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                check("pop_unexpected", 32'(parallel_data), 32'hFFFF_FFFF);
            end else begin
                check("pop_data", 32'(parallel_data), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            rx_enable = 1'b1;
            serial_in = w[7-i];
            tick();
        end
    endtask

    task automatic send_word(input logic [7:0] w, input bit push);
        if (push) sb_q.push_back(w);
        send_bits(w, DATA_WIDTH);
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        rx_enable = 1'b1;
        serial_in = ^w;
        tick();
`endif
    endtask

    task automatic pop_one();
        rx_enable = 1'b0;
        rx_ready  = 1'b1;
        tick();
        rx_ready  = 1'b0;
        check("valid_after_pop", 32'(rx_valid), 32'd0);
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        rx_enable = 1'b0;
        serial_in = 1'b0;
        rx_ready  = 1'b0;
        repeat (3) tick();
        check("rst_data", 32'(parallel_data), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        rst = 1'b0;

        // single word, no consumer
        send_word(8'hA5, 1'b1);
        rx_enable = 1'b0;
        check("a5_valid", 32'(rx_valid), 32'd1);
        check("a5_data", 32'(parallel_data), 32'hA5);
        check("a5_overrun", 32'(overrun), 32'd0);
        check("a5_frame_err", 32'(frame_err), 32'd0);
        tick();
        check("a5_valid_held", 32'(rx_valid), 32'd1);
        pop_one();

        // back-to-back words under continuous enable
        base = pop_cyc.size();
        rx_ready = 1'b1;
        send_word(8'h3C, 1'b1);
        send_word(8'hC3, 1'b1);
        rx_enable = 1'b0;
        tick();
        tick();
        rx_ready = 1'b0;
        check("b2b_pops", 32'(pop_cyc.size() - base), 32'd2);
        if (pop_cyc.size() - base == 2)
            check("b2b_spacing", 32'(pop_cyc[base+1] - pop_cyc[base]), 32'(FRAME));
        check("b2b_overrun", 32'(overrun), 32'd0);
        check("b2b_valid", 32'(rx_valid), 32'd0);

        // overrun: second word dropped while the first is unread
        send_word(8'h11, 1'b1);
        rx_enable = 1'b0;
        tick();
        send_word(8'h22, 1'b0);
        rx_enable = 1'b0;
        check("ovr_data", 32'(parallel_data), 32'h11);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        pop_one();
        tick();
        check("ovr_sticky", 32'(overrun), 32'd1);

        // frame abort after 4 bits
        send_bits(8'hF0, 4);
        rx_enable = 1'b0;
        tick();
        check("abort_frame_err", 32'(frame_err), 32'd1);
        check("abort_valid", 32'(rx_valid), 32'd0);
        tick();
        check("abort_frame_err_pulse", 32'(frame_err), 32'd0);
        send_word(8'h5A, 1'b1);
        rx_enable = 1'b0;
        check("5a_data", 32'(parallel_data), 32'h5A);
        check("5a_valid", 32'(rx_valid), 32'd1);
        pop_one();

        // reset mid-word with a full holding register
        send_word(8'h66, 1'b0);
        check("pre_rst_valid", 32'(rx_valid), 32'd1);
        send_bits(8'hB0, 5);
        rx_enable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_data", 32'(parallel_data), 32'd0);
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_frame_err", 32'(frame_err), 32'd0);
        check("mid_rst_parity_err", 32'(parity_err), 32'd0);
        send_word(8'hFF, 1'b1);
        rx_enable = 1'b0;
        check("ff_data", 32'(parallel_data), 32'hFF);
        check("ff_valid", 32'(rx_valid), 32'd1);
        pop_one();

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        // 0x07 has three ones: parity bit 1 is correct, 0 is wrong
        sb_q.push_back(8'h07);
        send_bits(8'h07, DATA_WIDTH);
        rx_enable = 1'b1;
        serial_in = 1'b1;
        tick();
        rx_enable = 1'b0;
        check("par_ok_err", 32'(parity_err), 32'd0);
        check("par_ok_data", 32'(parallel_data), 32'h07);
        pop_one();
        sb_q.push_back(8'h07);
        send_bits(8'h07, DATA_WIDTH);
        rx_enable = 1'b1;
        serial_in = 1'b0;
        tick();
        rx_enable = 1'b0;
        check("par_bad_err", 32'(parity_err), 32'd1);
        check("par_bad_data", 32'(parallel_data), 32'h07);
        check("par_bad_valid", 32'(rx_valid), 32'd1);
        tick();
        check("par_bad_pulse", 32'(parity_err), 32'd0);
        pop_one();
`else
        check("no_parity_err", 32'(parity_err), 32'd0);
`endif

        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("pop_total", 32'(pop_cyc.size()), 32'(NUM_POPS));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
